// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed p0 priority.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter logic [31:0] MEM_DEPTH = 32'h0010_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        mem_read_write,
  output logic [1:0]  mem_access_size,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + {1'b0, MEM_DEPTH} - 33'd1;

  state_t      state;
  logic        cmd_we;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_port;

  logic        grant_valid;
  logic        grant_port;
  logic        cmd_err;
  logic [32:0] last_byte;
  logic [31:0] rd_capture;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic        last_grant;
`endif

  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant_valid = p0_req | p1_req;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    grant_port  = (p0_req && p1_req) ? ~last_grant : ~p0_req;
`else
    grant_port  = ~p0_req;
`endif
  end

  // Range check in 33 bits so a request near 32'hFFFFFFFF cannot wrap into range.
  always_comb begin
    last_byte = {1'b0, cmd_addr};
    case (cmd_size)
      2'd0:    last_byte = {1'b0, cmd_addr};
      2'd1:    last_byte = {1'b0, cmd_addr} + 33'd1;
      default: last_byte = {1'b0, cmd_addr} + 33'd3;
    endcase
    cmd_err = ((cmd_size == 2'd1) && cmd_addr[0])
           || (cmd_size[1] && (cmd_addr[1:0] != 2'b00))
           || (cmd_addr < BASE_ADDR)
           || (last_byte > LAST_ADDR);
  end

  always_comb begin
    rd_capture = 32'd0;
    if (!cmd_we && !cmd_err) begin
      case (cmd_size)
        2'd0:    rd_capture = {24'd0, mem_data_out[7:0]};
        2'd1:    rd_capture = {16'd0, mem_data_out[15:0]};
        default: rd_capture = mem_data_out;
      endcase
    end
  end

  // Outside BUSY the memory sees a harmless in-range read of BASE_ADDR.
  always_comb begin
    mem_read_write  = 1'b0;
    mem_access_size = 2'd2;
    mem_address     = BASE_ADDR;
    mem_data_in     = 32'd0;
    if (state == BUSY) begin
      mem_read_write  = cmd_we & ~cmd_err;
      mem_access_size = cmd_size;
      mem_address     = cmd_addr;
      mem_data_in     = cmd_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_we    <= 1'b0;
      cmd_size  <= 2'd2;
      cmd_addr  <= BASE_ADDR;
      cmd_wdata <= 32'd0;
      cmd_port  <= 1'b0;
      p0_ack    <= 1'b0;
      p0_err    <= 1'b0;
      p0_rdata  <= 32'd0;
      p1_ack    <= 1'b0;
      p1_err    <= 1'b0;
      p1_rdata  <= 32'd0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cmd_port  <= grant_port;
            cmd_we    <= grant_port ? p1_we    : p0_we;
            cmd_size  <= grant_port ? p1_size  : p0_size;
            cmd_addr  <= grant_port ? p1_addr  : p0_addr;
            cmd_wdata <= grant_port ? p1_wdata : p0_wdata;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant <= grant_port;
`endif
            state     <= BUSY;
          end
        end
        BUSY: begin
          p0_ack   <= ~cmd_port;
          p0_err   <= ~cmd_port & cmd_err;
          p0_rdata <= cmd_port ? 32'd0 : rd_capture;
          p1_ack   <= cmd_port;
          p1_err   <= cmd_port & cmd_err;
          p1_rdata <= cmd_port ? rd_capture : 32'd0;
          state    <= RESP;
        end
        RESP: begin
          p0_ack   <= 1'b0;
          p0_err   <= 1'b0;
          p0_rdata <= 32'd0;
          p1_ack   <= 1'b0;
          p1_err   <= 1'b0;
          p1_rdata <= 32'd0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port, byte-addressable data memory. It shares the memory between requester 0 (core load/store unit) and requester 1 (debug/loader port). It registers each granted command, drives the memory for exactly one cycle, and captures the combinational read data. It rejects misaligned and out-of-range accesses without touching memory.

## Interface
- BASE_ADDR, 32'h01000000, first byte address of data memory
- MEM_DEPTH, 32'h00100000, memory size in bytes; must equal the memory's depth
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- pN_req  in  1  request from requester N (N = 0, 1); held until pN_ack
- pN_we  in  1  1 = write, 0 = read
- pN_size  in  2  0 byte, 1 half-word, 2/3 word
- pN_addr  in  32  byte address
- pN_wdata  in  32  write data, LSB-aligned
- pN_ack  out  1  one-cycle completion pulse
- pN_err  out  1  valid with pN_ack; 1 = access rejected
- pN_rdata  out  32  read data, zero-extended, valid with pN_ack
- mem_read_write  out  1  memory write enable
- mem_access_size  out  2  to memory access_size
- mem_address  out  32  to memory address
- mem_data_in  out  32  to memory data_in
- mem_data_out  in  32  from memory data_out (combinational read)

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One or both pN_req high: select a winner, latch its we/size/addr/wdata and port id into the command register, then go to BUSY.
- Contention with DMEM_ARB_ROUND_ROBIN_EN set: grant the port not granted last. last_grant resets to 1, so p0 wins the first contention.
- Error check, evaluated on the latched command in BUSY. An access is an error if either holds:
  - Misaligned: half-word with addr[0]=1, or word with addr[1:0]≠0.
  - Out of range: addr < BASE_ADDR, or addr+bytes−1 > BASE_ADDR+MEM_DEPTH−1. Compute in 33 bits so the sum does not wrap.
- BUSY:
  - Drive mem_address, mem_access_size and mem_data_in from the command register.
  - mem_read_write = we AND NOT err. An erroneous write never reaches memory.
  - Capture read data into the rdata register: size 0 → {24'b0, mem_data_out[7:0]}, size 1 → {16'b0, [15:0]}, size 2/3 → full word. Capture 0 on error or write.
  - Go to RESP.
- RESP:
  - Assert ack and err on the owning port only. rdata is valid on that port.
  - Go to IDLE.
- The requester drops or changes pN_req at the edge that ends its ack cycle. A request seen in IDLE is always treated as new.
- Outside BUSY:
  - mem_read_write=0.
  - mem_address=BASE_ADDR, which keeps the memory index in range.
  - mem_access_size=2, mem_data_in=0.
- The non-owning port's ack/err stay 0. Its rdata holds 0.

## Timing
- Request sampled in IDLE cycle t: memory access in cycle t+1 (write commits at the edge ending t+1); ack in cycle t+2.
- Throughput: one transaction per 3 cycles. Back-to-back requests are granted in the IDLE cycle t+3.
- Reset values: state IDLE, all acks/errs 0, all rdata 0, mem_read_write 0, mem_address BASE_ADDR, mem_access_size 2, mem_data_in 0, last_grant 1.
- Reset asserted mid-transaction:
  - Outputs return to reset values immediately, because reset is asynchronous.
  - The pending transaction is discarded with no ack.
  - If reset is asserted in BUSY before the closing edge, the write is not performed.
- Requests arriving in BUSY/RESP wait; nothing is queued.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN defined: round-robin on contention using the last_grant register.
- Not defined: fixed priority; p0 always wins and p1 can starve. last_grant is not implemented, and all other behaviour is identical.

## Test plan
- p0 write word 32'hDEADBEEF to 32'h01000010, then read it back. Expect: ack at t+2 each, err=0, p0_rdata=32'hDEADBEEF, mem_read_write high for exactly one cycle.
- p1 byte write 8'hA5 to 32'h01000013, then p1 half read at 32'h01000012. Expect: rdata=32'h0000A5xx matching the prior byte 2; then a word read at 32'h01000010 returns 32'hA5ADBEEF.
- p0 half write at 32'h01000001 and p1 word read at 32'h00FFFFFC. Expect: both ack with err=1, rdata=0, mem_read_write never asserted, memory unchanged.
- Word read at BASE_ADDR+MEM_DEPTH−4 gives err=0. The same word read at BASE_ADDR+MEM_DEPTH−2 (half read at −1 misaligned aside) gives err=1. Word read at 32'hFFFFFFFC gives err=1 with no wrap.
- Both ports request continuously for 6 transactions. With the macro: grants p0,p1,p0,p1,p0,p1. Without the macro: all p0, and p1_ack never asserted.
- Assert reset_n=0 during BUSY of a write to 32'h01000020. Expect: outputs at reset values immediately, no ack, and a subsequent read of that location returns the old value.
